// File: rtl/mul_result_collector.sv
// Collects x1/x3/x7/x8 sequencer results into one checked record per grant
// and buffers the records in a small FIFO with a valid/ready output.
module mul_result_collector #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_grant,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4*DATA_W-1:0]   res_data,
  output logic                  res_err,
  output logic                  overflow,
  output logic [7:0]            abort_cnt
);
  localparam int AW = $clog2(DEPTH);

  // CAP1/CAP3/CAP7 are the states on the 1st/2nd/3rd cycle after the grant.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP1 = 2'd1;
  localparam logic [1:0] S_CAP3 = 2'd2;
  localparam logic [1:0] S_CAP7 = 2'd3;

  logic [1:0]          r_state;
  logic [DATA_W-1:0]   r_x1, r_x3, r_x7;
  logic [7:0]          r_abort;
  logic                r_ovf;

  logic [4*DATA_W-1:0] r_mem     [DEPTH];
  logic                r_mem_err [DEPTH];
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [AW:0]         r_count;

  logic [DATA_W-1:0]   w_m3, w_m7, w_m8;
  logic                w_err, w_commit, w_early, w_full, w_pop, w_push;

  assign w_m8     = r_x1 << 3;
  assign w_m3     = (r_x1 << 1) + r_x1;
  assign w_m7     = w_m8 - r_x1;
  assign w_err    = (r_x3 != w_m3) || (r_x7 != w_m7) || (in_data != w_m8);
  assign w_commit = (r_state == S_CAP7);
  assign w_early  = in_grant && ((r_state == S_CAP1) || (r_state == S_CAP3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x1    <= '0;
      r_x3    <= '0;
      r_x7    <= '0;
      r_abort <= '0;
    end else begin
      if (w_early && (r_abort != 8'hFF)) r_abort <= r_abort + 8'd1;
      case (r_state)
        S_IDLE: if (in_grant) begin
          r_x1    <= in_data;
          r_state <= S_CAP1;
        end
        S_CAP1: if (in_grant) begin
          r_x1    <= in_data;
          r_state <= S_CAP1;
        end else begin
          r_x3    <= in_data;
          r_state <= S_CAP3;
        end
        S_CAP3: if (in_grant) begin
          r_x1    <= in_data;
          r_state <= S_CAP1;
        end else begin
          r_x7    <= in_data;
          r_state <= S_CAP7;
        end
        default: begin
          // x8 arrives this cycle; a grant here is the normal back-to-back cadence
          if (in_grant) begin
            r_x1    <= in_data;
            r_state <= S_CAP1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = (r_count != '0) && res_ready;
  assign w_push = w_commit && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]     <= '0;
        r_mem_err[i] <= 1'b0;
      end
    end else begin
      if (w_commit && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_push) begin
        r_mem[r_wptr]     <= {in_data, r_x7, r_x3, r_x1};
        r_mem_err[r_wptr] <= w_err;
        r_wptr            <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign res_valid = (r_count != '0);
  assign res_data  = r_mem[r_rptr];
  assign res_err   = r_mem_err[r_rptr];
  assign overflow  = r_ovf;
  assign abort_cnt = r_abort;
endmodule
